bf_ram_arbiter: RTL and testbench

//  Shares the single data-array RAM (ramDualAccess) between two requesters: the brainfuckCore

---
 rtl/bf_pkg.sv | 15 +
 rtl/bf_arb_pick.sv | 22 ++
 rtl/bf_ram_arbiter.sv | 129 ++++++++++++
 tb/tb_bf_ram_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared constants for the brainfuck tape RAM arbiter: default widths, FSM encoding, requester IDs.
package bf_pkg;
  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    LOCK_WAIT = 2'd2,
    LOCKED    = 2'd3
  } bf_state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_HOST = 1'b1;
endpackage

// File: rtl/bf_arb_pick.sv
// Combinational requester pick: core wins unless the host has waited out the starvation limit.
module bf_arb_pick
  import bf_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic       i_core_req,
  input  logic       i_host_req,
  input  logic [3:0] i_starve_cnt,
  output logic       o_vld,
  output logic       o_id
);
  localparam logic [3:0] LIM = 4'(STARVE_MAX);

  logic w_starve;
  assign w_starve = i_host_req && (i_starve_cnt >= LIM);

  always_comb begin
    o_vld = i_core_req | i_host_req;
    o_id  = (i_core_req && !w_starve) ? REQ_CORE : REQ_HOST;
  end
endmodule

// File: rtl/bf_ram_arbiter.sv
// Tape RAM arbiter between brainfuckCore and host port; pipelined, core priority, host lock.
// Optional host starvation guard enabled by defining BF_ARB_STARVE_GUARD_EN.
module bf_ram_arbiter
  import bf_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_lock,
  output logic              host_owns,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);
  bf_state_t         r_state, w_next;
  logic              w_vld, w_id, w_core_go, w_host_go;
  logic [3:0]        w_starve_cnt;
  logic              r_core_gnt, r_host_gnt, r_ram_we, r_core_rv, r_host_rv;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata, r_core_hold, r_host_hold;

  bf_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .i_core_req  (core_req),
    .i_host_req  (host_req),
    .i_starve_cnt(w_starve_cnt),
    .o_vld       (w_vld),
    .o_id        (w_id)
  );

`ifdef BF_ARB_STARVE_GUARD_EN
  logic [3:0] r_starve_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     r_starve_cnt <= '0;
    else if (!host_req || w_host_go) r_starve_cnt <= '0;
    else if (w_core_go && r_starve_cnt != 4'hF) r_starve_cnt <= r_starve_cnt + 4'd1;
  end
  assign w_starve_cnt = r_starve_cnt;
`else
  assign w_starve_cnt = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // A lock raised while an access is on the RAM lines detours through LOCK_WAIT so it drains first.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = host_lock ? LOCKED : (w_vld ? ISSUE : IDLE);
      ISSUE:     w_next = host_lock ? LOCK_WAIT : (w_vld ? ISSUE : IDLE);
      LOCK_WAIT: w_next = host_lock ? LOCKED : IDLE;
      LOCKED:    w_next = host_lock ? LOCKED : IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    w_core_go = 1'b0;
    w_host_go = 1'b0;
    case (r_state)
      IDLE, ISSUE: begin
        w_core_go = !host_lock && w_vld && (w_id == REQ_CORE);
        w_host_go = !host_lock && w_vld && (w_id == REQ_HOST);
      end
      LOCKED:  w_host_go = host_lock && host_req;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_core_gnt  <= 1'b0;
      r_host_gnt  <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_core_rv   <= 1'b0;
      r_host_rv   <= 1'b0;
      r_core_hold <= '0;
      r_host_hold <= '0;
    end else begin
      r_core_gnt <= w_core_go;
      r_host_gnt <= w_host_go;
      r_ram_we   <= (w_core_go && core_we) || (w_host_go && host_we);
      if (w_core_go) begin
        r_ram_addr  <= core_addr;
        r_ram_wdata <= core_wdata;
      end else if (w_host_go) begin
        r_ram_addr  <= host_addr;
        r_ram_wdata <= host_wdata;
      end
      r_core_rv <= r_core_gnt && !r_ram_we;
      r_host_rv <= r_host_gnt && !r_ram_we;
      if (r_core_rv) r_core_hold <= ram_rdata;
      if (r_host_rv) r_host_hold <= ram_rdata;
    end
  end

  assign core_gnt    = r_core_gnt;
  assign host_gnt    = r_host_gnt;
  assign core_rvalid = r_core_rv;
  assign host_rvalid = r_host_rv;
  assign core_rdata  = r_core_rv ? ram_rdata : r_core_hold;
  assign host_rdata  = r_host_rv ? ram_rdata : r_host_hold;
  assign host_owns   = (r_state == LOCKED);
  assign ram_addr    = r_ram_addr;
  assign ram_wdata   = r_ram_wdata;
  assign ram_we      = r_ram_we;
endmodule

// File: tb/tb_bf_ram_arbiter.sv
// Directed bench for bf_ram_arbiter with a behavioural 512x8 synchronous RAM model.
module tb_bf_ram_arbiter;
  import bf_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       core_req, core_we, host_req, host_we, host_lock;
  logic [8:0] core_addr, host_addr;
  logic [7:0] core_wdata, host_wdata;
  logic       core_gnt, core_rvalid, host_gnt, host_rvalid, host_owns, ram_we;
  logic [7:0] core_rdata, host_rdata, ram_wdata, ram_rdata;
  logic [8:0] ram_addr;

  logic [7:0]   mem [512];
  logic [511:0] wr_seen;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bf_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_lock(host_lock), .host_owns(host_owns),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  // Unwritten cells read back as addr^0xA5 so reads of fresh cells are still predictable.
  always @(posedge clk) begin
    if (reset) wr_seen <= '0;
    else if (ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      wr_seen[ram_addr] <= 1'b1;
    end
    ram_rdata <= wr_seen[ram_addr] ? mem[ram_addr] : (8'(ram_addr) ^ 8'hA5);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic core_read(input logic [8:0] a, input logic [7:0] exp, input string tag);
    logic seen;
    core_req = 1'b1; core_we = 1'b0; core_addr = a;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick;
      if (core_gnt) seen = 1'b1;
    end
    core_req = 1'b0;
    chk({tag, "_gnt"}, 32'(seen), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick;
      if (core_rvalid) begin
        seen = 1'b1;
        chk(tag, 32'(core_rdata), 32'(exp));
      end
    end
    chk({tag, "_rv"}, 32'(seen), 32'd1);
  endtask

  initial begin
    int ccnt, hcnt, hat, hg, cg, rv;
    logic seen;
    reset = 1'b1; host_lock = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) tick;
    chk("rst_cgnt",  32'(core_gnt),   32'd0);
    chk("rst_ramwe", 32'(ram_we),     32'd0);
    chk("rst_addr",  32'(ram_addr),   32'd0);
    chk("rst_wdata", 32'(ram_wdata),  32'd0);
    chk("rst_crd",   32'(core_rdata), 32'd0);
    chk("rst_owns",  32'(host_owns),  32'd0);
    reset = 1'b0;
    tick;

    // 1: core write then read back
    core_req = 1'b1; core_we = 1'b1; core_addr = 9'h005; core_wdata = 8'h2A;
    @(negedge clk);
    chk("t1_gnt_n", 32'(core_gnt), 32'd0);
    tick;
    chk("t1_gnt", 32'(core_gnt), 32'd1);
    chk("t1_we",  32'(ram_we),   32'd1);
    chk("t1_adr", 32'(ram_addr), 32'h005);
    chk("t1_wd",  32'(ram_wdata), 32'h2A);
    core_req = 1'b0;
    tick;
    chk("t1_we1cyc", 32'(ram_we), 32'd0);
    core_req = 1'b1; core_we = 1'b0;
    tick;
    chk("t1_rgnt", 32'(core_gnt), 32'd1);
    chk("t1_rwe",  32'(ram_we),   32'd0);
    core_req = 1'b0;
    tick;
    chk("t1_rv", 32'(core_rvalid), 32'd1);
    chk("t1_rd", 32'(core_rdata),  32'h2A);
    tick;
    chk("t1_rv0",  32'(core_rvalid), 32'd0);
    chk("t1_hold", 32'(core_rdata),  32'h2A);

    // 2: simultaneous requests, core first
    core_req = 1'b1; core_we = 1'b0; core_addr = 9'h010;
    host_req = 1'b1; host_we = 1'b0; host_addr = 9'h005;
    tick;
    chk("t2_cgnt",  32'(core_gnt), 32'd1);
    chk("t2_hgnt0", 32'(host_gnt), 32'd0);
    core_req = 1'b0;
    tick;
    chk("t2_hgnt",  32'(host_gnt),    32'd1);
    chk("t2_cgnt0", 32'(core_gnt),    32'd0);
    chk("t2_crv",   32'(core_rvalid), 32'd1);
    chk("t2_crd",   32'(core_rdata),  32'hB5);
    host_req = 1'b0;
    tick;
    chk("t2_hrv", 32'(host_rvalid), 32'd1);
    chk("t2_hrd", 32'(host_rdata),  32'h2A);
    repeat (2) tick;

    // 3: core held 20 cycles with host waiting
    core_req = 1'b1; core_addr = 9'h020;
    host_req = 1'b1; host_addr = 9'h021;
    ccnt = 0; hcnt = 0; hat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick;
      if (core_gnt) ccnt++;
      if (host_gnt) begin
        hcnt++;
        hat = ccnt;
        host_req = 1'b0;
      end
      if (i == 20) core_req = 1'b0;
    end
`ifdef BF_ARB_STARVE_GUARD_EN
    chk("t3_host_at", 32'(hat), 32'd8);
`else
    chk("t3_host_at", 32'(hat), 32'd20);
`endif
    chk("t3_hcnt", 32'(hcnt), 32'd1);

    // 4: host lock during core traffic, bulk write, release
    core_req = 1'b1; core_we = 1'b0; core_addr = 9'h1FF;
    repeat (2) tick;
    host_lock = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick;
      if (host_owns) seen = 1'b1;
    end
    chk("t4_owns", 32'(seen), 32'd1);
    hg = 0; cg = 0;
    host_req = 1'b1; host_we = 1'b1;
    for (int a = 0; a < 512; a++) begin
      host_addr = 9'(a); host_wdata = 8'(a) ^ 8'h3C;
      tick;
      if (host_gnt) hg++;
      if (core_gnt) cg++;
    end
    host_req = 1'b0;
    chk("t4_hgnts", 32'(hg), 32'd512);
    chk("t4_cgnt0", 32'(cg), 32'd0);
    tick;
    host_lock = 1'b0;
    tick;
    chk("t4_owns0", 32'(host_owns), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (core_gnt) seen = 1'b1;
      else tick;
    end
    chk("t4_resume", 32'(seen), 32'd1);
    core_req = 1'b0;
    tick;
    chk("t4_rv",  32'(core_rvalid), 32'd1);
    chk("t4_rd",  32'(core_rdata),  32'hC3);
    tick;
    core_read(9'h000, 8'h3C, "t4_r000");
    core_read(9'h0AB, 8'h97, "t4_r0ab");

    // 5: async reset mid-read
    core_req = 1'b1; core_we = 1'b0; core_addr = 9'h005;
    tick;
    chk("t5_gnt", 32'(core_gnt), 32'd1);
    core_req = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("t5_gnt0",  32'(core_gnt),    32'd0);
    chk("t5_addr0", 32'(ram_addr),    32'd0);
    chk("t5_crd0",  32'(core_rdata),  32'd0);
    chk("t5_rv0",   32'(core_rvalid), 32'd0);
    tick;
    reset = 1'b0;
    rv = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (core_rvalid || host_rvalid) rv++;
    end
    chk("t5_norv", 32'(rv), 32'd0);
    chk("t5_idle", 32'(dut.r_state), 32'(IDLE));

    // 6: host write then core read of the same cell next cycle
    host_req = 1'b1; host_we = 1'b1; host_addr = 9'h1FF; host_wdata = 8'hFF;
    tick;
    chk("t6_hgnt", 32'(host_gnt), 32'd1);
    chk("t6_we",   32'(ram_we),   32'd1);
    host_req = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 9'h1FF;
    tick;
    chk("t6_cgnt", 32'(core_gnt), 32'd1);
    chk("t6_addr", 32'(ram_addr), 32'h1FF);
    core_req = 1'b0;
    tick;
    chk("t6_rv", 32'(core_rvalid), 32'd1);
    chk("t6_rd", 32'(core_rdata),  32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
